// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one cmd/rsp handshake into a single AXI4-Lite write
// or read, one transaction outstanding, with a sticky handshake-wait timeout flag.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int TIMEOUT_W          = 16
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]                      rsp_resp,
    output logic                            timeout_err,
    input  logic                            timeout_clr,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);
    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R, RSP} state_t;

    localparam logic                 TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t state, state_n;

    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic rsp_valid_q, rsp_write_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_data_q;
    logic [1:0]                      rsp_resp_q;
    logic [TIMEOUT_W-1:0]            tcnt;
    logic                            tout_q;

    logic accept, b_hs, r_hs, busy, tset;

    assign accept = (state == IDLE) && cmd_valid;
    assign b_hs   = bready_q && m_axi_bvalid;
    assign r_hs   = rready_q && m_axi_rvalid;
    assign busy   = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_R);
    assign tset   = TO_EN && busy && (tcnt == TO_LAST);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_n;
    end

    // Each valid is set on entry, so a low valid inside WR means that channel is done.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (cmd_valid) state_n = cmd_write ? WR : RD_A;
            WR:   if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) state_n = WR_B;
            WR_B: if (b_hs) state_n = RSP;
            RD_A: if (arvalid_q && m_axi_arready) state_n = RD_R;
            RD_R: if (r_hs) state_n = RSP;
            RSP:  if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                awvalid_q <= cmd_write;
                wvalid_q  <= cmd_write;
                arvalid_q <= !cmd_write;
            end else begin
                if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
                if (arvalid_q && m_axi_arready) arvalid_q <= 1'b0;
            end

            if (state == WR && state_n == WR_B) bready_q <= 1'b1;
            else if (b_hs)                      bready_q <= 1'b0;

            if (arvalid_q && m_axi_arready) rready_q <= 1'b1;
            else if (r_hs)                  rready_q <= 1'b0;

            if (b_hs) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_resp_q  <= m_axi_bresp;
            end else if (r_hs) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= 1'b0;
                rsp_data_q  <= m_axi_rdata;
                rsp_resp_q  <= m_axi_rresp;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Wait counter restarts on every state entry and saturates; the transaction is never aborted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tcnt   <= '0;
            tout_q <= 1'b0;
        end else begin
            if (state_n != state)        tcnt <= '0;
            else if (busy && tcnt != '1) tcnt <= tcnt + TIMEOUT_W'(1);

            if (tset)             tout_q <= 1'b1;
            else if (timeout_clr) tout_q <= 1'b0;
        end
    end

    assign cmd_ready     = (state == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_resp      = rsp_resp_q;
    assign timeout_err   = tout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed commands against a configurable AXI4-Lite
// slave model, responses checked by a scoreboard monitor.
module tb_axi_lite_cmd_master;
    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        timeout_err, timeout_clr = 1'b0;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16), .TIMEOUT_W(16)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .timeout_err(timeout_err), .timeout_clr(timeout_clr),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int errs = 0, checks = 0;
    rsp_t sb[$];

    // slave configuration, written by the stimulus
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 1, r_dly = 1, hold_n = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;

    // handshake bookkeeping, written only at posedge
    int aw_hs = 0, w_hs = 0, rsp_done = 0;
    logic aw_got = 0, w_got = 0, wr_pend = 0, rd_pend = 0;

    int mon_popped = 0, mon_held = 0, rsp_len = 0;
    rsp_t mon_cur = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave responses come one cycle after the request handshake cycle (registered slave).
    initial begin
        int aw_w = 0, w_w = 0, ar_w = 0, b_w = 0, r_w = 0;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_w = 0; w_w = 0; ar_w = 0; b_w = 0; r_w = 0;
            end else begin
                awready = awvalid && (aw_w >= aw_dly);
                if (!awvalid) aw_w = 0; else if (!awready) aw_w++;
                wready = wvalid && (w_w >= w_dly);
                if (!wvalid) w_w = 0; else if (!wready) w_w++;
                arready = arvalid && (ar_w >= ar_dly);
                if (!arvalid) ar_w = 0; else if (!arready) ar_w++;
                if (!wr_pend) begin bvalid = 0; b_w = 0; end
                else if (!bvalid) begin
                    if (b_w >= b_dly) begin bvalid = 1; bresp = b_resp_cfg; end
                    else b_w++;
                end
                if (!rd_pend) begin rvalid = 0; r_w = 0; end
                else if (!rvalid) begin
                    if (r_w >= r_dly) begin rvalid = 1; rdata = r_data_cfg; rresp = r_resp_cfg; end
                    else r_w++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!aresetn) begin
                aw_got = 0; w_got = 0; wr_pend = 0; rd_pend = 0;
            end else begin
                if (awvalid && awready) begin aw_hs++; aw_got = 1; end
                if (wvalid && wready) begin w_hs++; w_got = 1; end
                if (aw_got && w_got) begin wr_pend = 1; aw_got = 0; w_got = 0; end
                if (bvalid && bready) wr_pend = 0;
                if (arvalid && arready) rd_pend = 1;
                if (rvalid && rready) rd_pend = 0;
                if (rsp_valid && rsp_ready) rsp_done++;
            end
        end
    end

    // Scoreboard monitor: pops on the first cycle of each response, checks stability after.
    initial begin
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                rsp_ready = 0; mon_popped = rsp_done; mon_held = 0;
            end else if (rsp_valid) begin
                if (mon_popped == rsp_done) begin
                    mon_popped++;
                    mon_held = 0;
                    chk("sb_has_entry", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mon_cur = sb.pop_front();
                        chk("rsp_write", rsp_write, mon_cur.wr);
                        chk("rsp_data", rsp_data, mon_cur.data);
                        chk("rsp_resp", rsp_resp, mon_cur.resp);
                    end
                end else begin
                    chk("rsp_stable", {rsp_write, rsp_data, rsp_resp}, mon_cur);
                end
                chk("cmd_ready_in_rsp", cmd_ready, 0);
                rsp_ready = (mon_held >= hold_n);
                mon_held++;
                rsp_len = mon_held;
            end else begin
                rsp_ready = 0;
            end
        end
    end

    // Returns at the negedge of cycle 1 (first cycle after acceptance).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        sb.push_back(rsp_t'{wr, ed, er});
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (rsp_done < target && n < 200) begin @(negedge clk); n++; end
        chk("rsp_count", rsp_done, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errs=%0d checks=%0d", errs, checks);
        $fatal(1);
    end

    initial begin
        int a0, w0, cnt;
        logic ok, early;

        repeat (2) @(negedge clk);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        chk("rst_addr", {awaddr, araddr}, 64'h0);
        chk("rst_wdata", {wdata, wstrb}, 36'h0);
        chk("rst_prot", {awprot, arprot}, 6'b0);
        chk("rst_rsp", {rsp_write, rsp_data, rsp_resp}, 35'h0);
        chk("rst_timeout", timeout_err, 0);
        aresetn = 1;
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // zero-wait write
        issue(1, 32'h04, 32'h0000_1234, 4'hF, 32'h0, 2'b00);
        chk("t1_c1_awv_wv", {awvalid, wvalid}, 2'b11);
        chk("t1_c1_payload", {awaddr, wdata, wstrb}, {32'h04, 32'h0000_1234, 4'hF});
        @(negedge clk);
        chk("t1_c2_bready", {bready, awvalid, wvalid}, 3'b100);
        @(negedge clk);
        chk("t1_c3_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("t1_c4_rsp_valid", rsp_valid, 1);
        wait_rsp(1);
        chk("t1_cmd_ready", cmd_ready, 1);

        // W accepted 3 cycles before AW
        aw_dly = 3; a0 = aw_hs; w0 = w_hs;
        issue(1, 32'h08, 32'hA5A5_0001, 4'h3, 32'h0, 2'b00);
        chk("t2_c1", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        chk("t2_c2", {awvalid, wvalid}, 2'b10);
        @(negedge clk);
        chk("t2_c3", {awvalid, wvalid}, 2'b10);
        @(negedge clk);
        chk("t2_c4", {awvalid, wvalid, bready}, 3'b100);
        @(negedge clk);
        chk("t2_c5", {awvalid, wvalid, bready}, 3'b001);
        wait_rsp(2);
        chk("t2_aw_hs", aw_hs - a0, 1);
        chk("t2_w_hs", w_hs - w0, 1);
        aw_dly = 0;

        // read with delayed rvalid
        r_dly = 5; r_data_cfg = 32'hDEAD_BEEF; r_resp_cfg = 2'b00;
        issue(0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00);
        chk("t3_arvalid", {arvalid, araddr}, {1'b1, 32'h10});
        @(negedge clk);
        ok = 1; cnt = 0;
        while (!rsp_valid && cnt < 50) begin
            if (!rready) ok = 0;
            cnt++;
            @(negedge clk);
        end
        chk("t3_rready_held", ok, 1);
        chk("t3_wait_cycles", cnt, 6);
        wait_rsp(3);
        r_dly = 1;

        // SLVERR write, response back-pressured 6 cycles
        b_resp_cfg = 2'b10; hold_n = 6;
        issue(1, 32'h0C, 32'hFFFF_0000, 4'hC, 32'h0, 2'b10);
        wait_rsp(4);
        chk("t4_rsp_len", rsp_len, 7);
        chk("t4_after", {cmd_ready, rsp_valid}, 2'b10);
        b_resp_cfg = 2'b00; hold_n = 0;

        // timeout on a stalled AR channel
        ar_dly = 1000; r_data_cfg = 32'h0000_00A5;
        issue(0, 32'h20, 32'h0, 4'h0, 32'h0000_00A5, 2'b00);
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            if (timeout_err) early = 1;
            @(negedge clk);
        end
        chk("t5_no_early_timeout", early, 0);
        chk("t5_timeout_set", {timeout_err, arvalid}, 2'b11);
        timeout_clr = 1;
        @(negedge clk);
        timeout_clr = 0;
        chk("t5_timeout_clr", {timeout_err, arvalid}, 2'b01);
        ar_dly = 0;
        wait_rsp(5);
        chk("t5_timeout_after", timeout_err, 0);

        // reset while waiting in WR_B
        b_dly = 10;
        issue(1, 32'h14, 32'h5555_AAAA, 4'hF, 32'h0, 2'b00);
        @(negedge clk);
        chk("t6_bready_before", bready, 1);
        #2 aresetn = 0;
        #1 chk("t6_async_drop", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        aresetn = 1;
        @(negedge clk);
        chk("t6_after_rst", {cmd_ready, rsp_valid}, 2'b10);
        b_dly = 1;
        issue(1, 32'h18, 32'h0000_0042, 4'h1, 32'h0, 2'b00);
        wait_rsp(6);
        chk("t6_w_payload", {awaddr, wdata}, {32'h18, 32'h0000_0042});

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
